// File: rtl/stream_deserializer.sv
// Valid/ready width converter: packs RATIO narrow DLEN-bit beats into one wide word.
// i_last closes a word early; o_keep then flags which lanes were actually filled.
module stream_deserializer #(
    parameter int DLEN  = 8,
    parameter int RATIO = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DLEN-1:0]       i_data,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DLEN*RATIO-1:0] o_data,
    output logic [RATIO-1:0]      o_keep,
    output logic                  o_last
);

    localparam int CW = $clog2(RATIO);
    localparam int WW = DLEN * RATIO;
    localparam int AW = DLEN * (RATIO - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0]   cnt_r;
    logic [AW-1:0]   acc_r;
    logic            o_valid_r;
    logic [WW-1:0]   o_data_r;
    logic [RATIO-1:0] o_keep_r;
    logic            o_last_r;

    logic            ihs_s;
    logic            ohs_s;
    logic            done_s;
    logic [WW-1:0]   word_s;
    logic [RATIO-1:0] keep_s;
    logic [AW-1:0]   acc_nxt_s;

    assign o_ready = !o_valid_r | i_ready;
    assign ihs_s   = i_valid & o_ready;
    assign ohs_s   = o_valid_r & i_ready;
    assign done_s  = ihs_s & (i_last | (cnt_r == CNT_MAX));

    assign o_valid = o_valid_r;
    assign o_data  = o_data_r;
    assign o_keep  = o_keep_r;
    assign o_last  = o_last_r;

    // Next-word assembly: stored lanes below cnt, current beat at cnt, zeros above.
    always_comb begin
        word_s    = {WW{1'b0}};
        keep_s    = {RATIO{1'b0}};
        acc_nxt_s = acc_r;
        for (int k = 0; k < RATIO - 1; k++) begin
            word_s[k*DLEN +: DLEN]    = (k < int'(cnt_r))  ? acc_r[k*DLEN +: DLEN] :
                                        (k == int'(cnt_r)) ? i_data : {DLEN{1'b0}};
            acc_nxt_s[k*DLEN +: DLEN] = (k == int'(cnt_r)) ? i_data : acc_r[k*DLEN +: DLEN];
        end
        word_s[(RATIO-1)*DLEN +: DLEN] = (cnt_r == CNT_MAX) ? i_data : {DLEN{1'b0}};
        for (int k = 0; k < RATIO; k++) begin
            keep_s[k] = (k <= int'(cnt_r));
        end
    end

    // Lane counter, accumulator and registered output word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {AW{1'b0}};
            o_valid_r <= 1'b0;
            o_data_r  <= {WW{1'b0}};
            o_keep_r  <= {RATIO{1'b0}};
            o_last_r  <= 1'b0;
        end else if (done_s) begin
            // A completing beat overrides any simultaneous drain, so no bubble appears.
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {AW{1'b0}};
            o_valid_r <= 1'b1;
            o_data_r  <= word_s;
            o_keep_r  <= keep_s;
            o_last_r  <= i_last;
        end else begin
            if (ihs_s) begin
                cnt_r <= cnt_r + CNT_ONE;
                acc_r <= acc_nxt_s;
            end else begin
                cnt_r <= cnt_r;
                acc_r <= acc_r;
            end
            if (ohs_s) begin
                o_valid_r <= 1'b0;
                o_data_r  <= {WW{1'b0}};
                o_keep_r  <= {RATIO{1'b0}};
                o_last_r  <= 1'b0;
            end else begin
                o_valid_r <= o_valid_r;
                o_data_r  <= o_data_r;
                o_keep_r  <= o_keep_r;
                o_last_r  <= o_last_r;
            end
        end
    end

endmodule
